// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives a/b/c through vectors 000..111, holds each for
// HOLD_CYCLES clocks, samples y on the last hold cycle and compares it
// against the EXPECTED table. Reports per-vector fails, a count and pass/done.
//
// Handshake: start is a single-cycle (or level) request with no ready.
// It is honoured only when the FSM is in IDLE or DONE, and ignored while busy=1.
module truth_table_sweeper #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [7:0] EXPECTED    = 8'h31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask,
    output logic [1:0] state_dbg
);

    localparam int            CW       = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]    state;
    logic [2:0]    idx;
    logic [CW-1:0] hold_cnt;

    // Sweep FSM: vector sequencing, hold timing and result accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            hold_cnt  <= '0;
            err_count <= 4'd0;
            fail_mask <= 8'h00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        idx       <= 3'd0;
                        hold_cnt  <= '0;
                        err_count <= 4'd0;
                        fail_mask <= 8'h00;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == LAST_CNT) begin
                        // Written as match/else so an unknown y lands in the
                        // mismatch branch in simulation.
                        if (y == EXPECTED[idx]) begin
                        end else begin
                            fail_mask[idx] <= 1'b1;
                            err_count      <= err_count + 4'd1;
                        end
                        hold_cnt <= '0;
                        if (idx == 3'd7) begin
                            state <= ST_DONE;
                            idx   <= 3'd0;  // stimulus returns to 000 in DONE
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; stimulus comes straight from idx.
    assign {a, b, c}  = idx;
    assign busy       = (state == ST_DRIVE);
    assign done       = (state == ST_DONE);
    assign pass       = done && (err_count == 4'd0);
    assign state_dbg  = state;

endmodule
